// File: rtl/nn_layer_sequencer_pkg.sv
// nn_parameters: layer sizes of the speech-recognition dense stack and the
// sequencer's shared types.
`default_nettype none

package nn_parameters;

  localparam int IN_SIZE_1  = 26;
  localparam int OUT_SIZE_1 = 64;
  localparam int IN_SIZE_2  = OUT_SIZE_1;
  localparam int IN_SIZE_3  = 32;
  localparam int NUM_DENSE  = 3;

  // Each layer runs one edge per input element plus one ReLU edge.
  localparam int LAYER_LEN [NUM_DENSE] = '{IN_SIZE_1 + 1, IN_SIZE_2 + 1, IN_SIZE_3 + 1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } nn_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/nn_layer_sequencer_step_counter.sv
// nn_step_counter: clearable step counter that flags the final step of a
// runtime-selected pass length.
`default_nettype none

module nn_step_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = en_i && (cnt_q == (len_i - CNT_W'(1)));

endmodule

`default_nettype wire

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: releases the dense layers from reset one after another,
// timing each fixed-length pass, and hands the result over valid/ready.
`default_nettype none

module nn_layer_sequencer
  import nn_parameters::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int LEN_1      = LAYER_LEN[0],
  parameter int LEN_2      = LAYER_LEN[1],
  parameter int LEN_3      = LAYER_LEN[2],
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  feat_load_o,
  output logic [NUM_LAYERS-1:0] layer_rst_o,
  output logic [1:0]            layer_idx_o,
  output logic                  busy_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam logic [1:0] LAST_K = 2'(NUM_LAYERS - 1);

  nn_seq_state_t         state_q;
  logic [1:0]            k_q;
  logic [NUM_LAYERS-1:0] layer_rst_q;
  logic [NUM_LAYERS-1:0] layer_rst_d;
  logic [CNT_W-1:0]      len_sel;
  logic                  step_last;

  always_comb begin
    case (k_q)
      2'd0:    len_sel = CNT_W'(LEN_1);
      2'd1:    len_sel = CNT_W'(LEN_2);
      default: len_sel = CNT_W'(LEN_3);
    endcase
  end

  nn_step_counter #(
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q == CLEAR),
    .en_i    (state_q == RUN),
    .len_i   (len_sel),
    .last_o  (step_last)
  );

  // Finished layers stay released so their frozen outputs keep feeding the next one.
  always_comb begin
    layer_rst_d = '1;
    for (int j = 0; j < NUM_LAYERS; j++) begin
      case (state_q)
        RUN, DONE: layer_rst_d[j] = !(j <= int'(k_q));
        CLEAR:     layer_rst_d[j] = !(j < int'(k_q));
        default:   layer_rst_d[j] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      layer_rst_q <= '1;
    end else begin
      layer_rst_q <= layer_rst_d;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            k_q     <= 2'd0;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          state_q <= RUN;
        end
        RUN: begin
          if (step_last) begin
            if (k_q == LAST_K) begin
              state_q <= DONE;
            end else begin
              k_q     <= k_q + 2'd1;
              state_q <= CLEAR;
            end
          end
        end
        default: begin
          if (out_ready_i) begin
            k_q     <= 2'd0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign feat_load_o = in_valid_i & in_ready_o;
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = (state_q == DONE);
  assign layer_idx_o = k_q;
  assign layer_rst_o = layer_rst_q;

endmodule

`default_nettype wire

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: edge-arithmetic reference model with a result
// scoreboard, directed scenarios and a randomized soak.
`default_nettype none

module tb_nn_layer_sequencer;

  localparam int NL = 3;
  localparam int LEN [NL] = '{26 + 1, 64 + 1, 32 + 1};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          feat_load;
  logic [NL-1:0] layer_rst;
  logic [1:0]    layer_idx;
  logic          busy;
  logic          out_valid;

  always #5 clk = ~clk;

  nn_layer_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .feat_load_o (feat_load),
    .layer_rst_o (layer_rst),
    .layer_idx_o (layer_idx),
    .busy_o      (busy),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Edge offsets from the accept edge: layer k enters CLEAR at start_off[k],
  // its reset drops at rel_off[k], the result is presented at done_off.
  int start_off [NL];
  int rel_off   [NL];
  int done_off;

  int m_a = -1;
  int m_h = -1;
  logic          e_ir  = 1'b1;
  logic          e_ov  = 1'b0;
  logic [NL-1:0] e_lr  = '1;
  logic [1:0]    e_idx = 2'd0;
  int exp_q [$];
  int dut_acc [$];
  logic prev_ov = 1'b0;

  initial begin
    int acc;
    acc = 0;
    for (int k = 0; k < NL; k++) begin
      start_off[k] = k + acc;
      rel_off[k]   = start_off[k] + 2;
      acc          = acc + LEN[k];
    end
    done_off = NL + acc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int c;
    cyc = cyc + 1;
    c   = cyc;
    if (rst) begin
      m_a = -1;
      m_h = -1;
      exp_q.delete();
    end else if (e_ir && in_valid) begin
      m_a = c;
      m_h = -1;
      exp_q.push_back(c + done_off);
    end else if (e_ov && out_ready) begin
      m_h = c;
    end
    e_ir = (m_a < 0) || (m_h >= 0);
    e_ov = (m_a >= 0) && (m_h < 0) && (c >= m_a + done_off);
    for (int k = 0; k < NL; k++) begin
      e_lr[k] = !((m_a >= 0) && (c >= m_a + rel_off[k]) && ((m_h < 0) || (c <= m_h)));
    end
    e_idx = 2'd0;
    if ((m_a >= 0) && (m_h < 0)) begin
      for (int k = 1; k < NL; k++) begin
        if (c >= m_a + start_off[k]) e_idx = 2'(k);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("in_ready", in_ready, e_ir);
      chk("busy", busy, !e_ir);
      chk("out_valid", out_valid, e_ov);
      chk("layer_rst", layer_rst, e_lr);
      chk("layer_idx", layer_idx, e_idx);
      chk("feat_load", feat_load, in_valid & e_ir);
      if (feat_load) dut_acc.push_back(cyc + 1);
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("result_edge", cyc, e);
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      if (e_ir && !busy) return;
    end
    chk({"timeout_idle_", tag}, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      if (e_ov && out_valid) return;
    end
    chk({"timeout_done_", tag}, 32'd0, 32'd1);
  endtask

  task automatic pulse_in();
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("reset_layer_rst", layer_rst, 3'b111);
    chk("reset_in_ready", in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #2;

    // Nominal single run
    pulse_in();
    wait_idle("nominal");

    // Backpressure in DONE
    out_ready = 1'b0;
    pulse_in();
    wait_done("bp");
    repeat (20) @(posedge clk);
    #2;
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_layer_rst", layer_rst, 3'b000);
    out_ready = 1'b1;
    wait_idle("bp");

    // Back-to-back with in_valid held high
    dut_acc.delete();
    in_valid = 1'b1;
    repeat (3 * (done_off + 2) + 5) @(posedge clk);
    #2;
    in_valid = 1'b0;
    wait_idle("b2b");
    for (int i = 1; i < dut_acc.size(); i++) begin
      chk("accept_spacing", dut_acc[i] - dut_acc[i-1], done_off + 2);
    end

    // Reset while layer 1 is running
    pulse_in();
    repeat (39) @(posedge clk);
    #2;
    chk("pre_rst_idx", layer_idx, 2'd1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("midrst_layer_rst", layer_rst, 3'b111);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    pulse_in();
    wait_idle("after_rst");

    // Randomized soak
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      in_valid  = ($urandom % 4) == 0;
      out_ready = ($urandom % 3) != 0;
      rst       = ($urandom % 700) == 0;
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle("soak");
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
